// File: rtl/arpas_lr_tally.sv
// arpas_lr_tally: tallies router left/right pulse events, tracks a saturating balance and requests inc/rev.
// Define ARPAS_TALLY_SYNC_EN to pass both inputs through 2-flop synchronizers (+2 cycles latency).
module arpas_lr_tally #(
   parameter int CW     = 8,
   parameter int THRESH = 4
) (
   input  logic          c,
   input  logic          rn,
   input  logic          left,
   input  logic          right,
   input  logic          clr,
   output logic [CW-1:0] left_cnt,
   output logic [CW-1:0] right_cnt,
   output logic [CW:0]   bal,
   output logic [1:0]    state,
   output logic          req_inc,
   output logic          req_rev,
   output logic          sat
);
   typedef enum logic [1:0] {BAL, LEAN_L, LEAN_R, FAULT} st_t;
   localparam logic signed [CW:0] BMAX = (CW+1)'((1 << CW) - 1);
   localparam logic signed [CW:0] TP   = (CW+1)'(THRESH);
   localparam logic signed [CW:0] T2   = (CW+1)'(2 * THRESH);
   localparam logic signed [CW:0] Z    = '0;
   logic l_in, r_in, l_q, r_q, ev_l, ev_r, l_full, r_full, up, dn, up_clip, dn_clip;
   logic signed [CW:0] b;
   st_t st;
`ifdef ARPAS_TALLY_SYNC_EN
   logic [1:0] l_s, r_s;
   always_ff @(posedge c or negedge rn)
      if (!rn) begin
         l_s <= '0;
         r_s <= '0;
      end else begin
         l_s <= {l_s[0], left};
         r_s <= {r_s[0], right};
      end
   assign l_in = l_s[1];
   assign r_in = r_s[1];
`else
   assign l_in = left;
   assign r_in = right;
`endif
   // edge flops are deliberately untouched by clr so a held input cannot re-fire
   always_ff @(posedge c or negedge rn)
      if (!rn) begin
         l_q <= 1'b0;
         r_q <= 1'b0;
      end else begin
         l_q <= l_in;
         r_q <= r_in;
      end
   assign ev_l    = l_in & ~l_q;
   assign ev_r    = r_in & ~r_q;
   assign l_full  = left_cnt == '1;
   assign r_full  = right_cnt == '1;
   assign up      = ev_l & ~ev_r;
   assign dn      = ev_r & ~ev_l;
   assign up_clip = up & (b == BMAX);
   assign dn_clip = dn & (b == -BMAX);
   always_ff @(posedge c or negedge rn)
      if (!rn) begin
         left_cnt  <= '0;
         right_cnt <= '0;
         b         <= '0;
         sat       <= 1'b0;
      end else if (clr) begin
         left_cnt  <= '0;
         right_cnt <= '0;
         b         <= '0;
         sat       <= 1'b0;
      end else begin
         if (ev_l && !l_full) left_cnt <= left_cnt + CW'(1);
         if (ev_r && !r_full) right_cnt <= right_cnt + CW'(1);
         if (up && !up_clip) b <= b + (CW+1)'(1);
         else if (dn && !dn_clip) b <= b - (CW+1)'(1);
         if ((ev_l && l_full) || (ev_r && r_full) || up_clip || dn_clip) sat <= 1'b1;
      end
   // monitor works on the registered balance, so it trails the counters by one edge
   always_ff @(posedge c or negedge rn)
      if (!rn) begin
         st      <= BAL;
         req_inc <= 1'b0;
         req_rev <= 1'b0;
      end else if (clr) begin
         st      <= BAL;
         req_inc <= 1'b0;
         req_rev <= 1'b0;
      end else begin
         req_inc <= 1'b0;
         req_rev <= 1'b0;
         case (st)
            BAL:
               if (b >= TP) begin
                  st      <= LEAN_L;
                  req_inc <= 1'b1;
               end else if (b <= -TP) begin
                  st      <= LEAN_R;
                  req_inc <= 1'b1;
               end
            LEAN_L:
               if (b <= Z) st <= BAL;
               else if (b >= T2) begin
                  st      <= FAULT;
                  req_rev <= 1'b1;
               end
            LEAN_R:
               if (b >= Z) st <= BAL;
               else if (b <= -T2) begin
                  st      <= FAULT;
                  req_rev <= 1'b1;
               end
            FAULT: st <= FAULT;
         endcase
      end
   assign bal   = b;
   assign state = st;
endmodule

// File: tb/tb_arpas_lr_tally.sv
// tb_arpas_lr_tally: cycle table with scoreboard queue for the CW=8 instance, plus a CW=4 instance for saturation.
module tb_arpas_lr_tally;
   typedef struct {
      bit l, r, k;
      int lc, rc, b, st;
      bit ri, rr;
   } vec_t;
   logic c = 0, rn = 0, left = 0, right = 0, clr = 0;
   logic [7:0] lc0, rc0;
   logic [8:0] b0;
   logic [1:0] st0, st1;
   logic ri0, rr0, s0, ri1, rr1, s1;
   logic [3:0] lc1, rc1;
   logic [4:0] b1;
   int n_chk = 0, n_err = 0;
   vec_t tbl[$];
   vec_t q[$];
   vec_t cur;

   arpas_lr_tally #(.CW(8), .THRESH(4)) u0 (
      .c(c), .rn(rn), .left(left), .right(right), .clr(clr),
      .left_cnt(lc0), .right_cnt(rc0), .bal(b0), .state(st0),
      .req_inc(ri0), .req_rev(rr0), .sat(s0));
   arpas_lr_tally #(.CW(4), .THRESH(4)) u1 (
      .c(c), .rn(rn), .left(left), .right(right), .clr(clr),
      .left_cnt(lc1), .right_cnt(rc1), .bal(b1), .state(st1),
      .req_inc(ri1), .req_rev(rr1), .sat(s1));

   always #5 c = ~c;

   task automatic chk(input string n, input int a, input int e);
      n_chk++;
      if (a != e) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
      end
   endtask

   function automatic void add(bit l, bit r, bit k, int lc, int rc, int b, int st, bit ri, bit rr);
      tbl.push_back('{l, r, k, lc, rc, b, st, ri, rr});
   endfunction

   always @(posedge c)
      if (q.size() > 0) begin
         cur = q.pop_front();
         #1;
         chk("left_cnt", int'(lc0), cur.lc);
         chk("right_cnt", int'(rc0), cur.rc);
         chk("bal", int'($signed(b0)), cur.b);
         chk("state", int'(st0), cur.st);
         chk("req_inc", int'(ri0), int'(cur.ri));
         chk("req_rev", int'(rr0), int'(cur.rr));
         chk("sat", int'(s0), 0);
      end

   initial begin
      // first event lands on the first post-reset edge, then clear
      add(1,0,0, 1,0,1,0, 0,0); add(0,0,0, 1,0,1,0, 0,0); add(0,0,1, 0,0,0,0, 0,0);
      // lean left with four pulses
      add(1,0,0, 1,0,1,0, 0,0); add(0,0,0, 1,0,1,0, 0,0);
      add(1,0,0, 2,0,2,0, 0,0); add(0,0,0, 2,0,2,0, 0,0);
      add(1,0,0, 3,0,3,0, 0,0); add(0,0,0, 3,0,3,0, 0,0);
      add(1,0,0, 4,0,4,0, 0,0); add(0,0,0, 4,0,4,1, 1,0); add(0,0,0, 4,0,4,1, 0,0);
      // recover with four right pulses
      add(0,1,0, 4,1,3,1, 0,0); add(0,0,0, 4,1,3,1, 0,0);
      add(0,1,0, 4,2,2,1, 0,0); add(0,0,0, 4,2,2,1, 0,0);
      add(0,1,0, 4,3,1,1, 0,0); add(0,0,0, 4,3,1,1, 0,0);
      add(0,1,0, 4,4,0,1, 0,0); add(0,0,0, 4,4,0,0, 0,0); add(0,0,0, 4,4,0,0, 0,0);
      add(0,0,1, 0,0,0,0, 0,0);
      // lean right into fault
      add(0,1,0, 0,1,-1,0, 0,0); add(0,0,0, 0,1,-1,0, 0,0);
      add(0,1,0, 0,2,-2,0, 0,0); add(0,0,0, 0,2,-2,0, 0,0);
      add(0,1,0, 0,3,-3,0, 0,0); add(0,0,0, 0,3,-3,0, 0,0);
      add(0,1,0, 0,4,-4,0, 0,0); add(0,0,0, 0,4,-4,2, 1,0);
      add(0,1,0, 0,5,-5,2, 0,0); add(0,0,0, 0,5,-5,2, 0,0);
      add(0,1,0, 0,6,-6,2, 0,0); add(0,0,0, 0,6,-6,2, 0,0);
      add(0,1,0, 0,7,-7,2, 0,0); add(0,0,0, 0,7,-7,2, 0,0);
      add(0,1,0, 0,8,-8,2, 0,0); add(0,0,0, 0,8,-8,3, 0,1);
      add(0,1,0, 0,9,-9,3, 0,0); add(0,0,0, 0,9,-9,3, 0,0);
      add(0,1,0, 0,10,-10,3, 0,0); add(0,0,0, 0,10,-10,3, 0,0);
      add(0,0,1, 0,0,0,0, 0,0); add(0,0,0, 0,0,0,0, 0,0);
      // simultaneous edges
      add(1,1,0, 1,1,0,0, 0,0); add(0,0,0, 1,1,0,0, 0,0);
      add(1,1,0, 2,2,0,0, 0,0); add(0,0,0, 2,2,0,0, 0,0);
      add(1,1,0, 3,3,0,0, 0,0); add(0,0,0, 3,3,0,0, 0,0);
      // held high counts once, re-arms after a low sample
      add(1,0,0, 4,3,1,0, 0,0); add(1,0,0, 4,3,1,0, 0,0); add(1,0,0, 4,3,1,0, 0,0);
      add(0,0,0, 4,3,1,0, 0,0); add(1,0,0, 5,3,2,0, 0,0);
      // clear collides with an event; edge flop survives clear
      add(0,0,0, 5,3,2,0, 0,0); add(1,0,1, 0,0,0,0, 0,0); add(1,0,0, 0,0,0,0, 0,0);
      add(0,0,0, 0,0,0,0, 0,0); add(1,0,0, 1,0,1,0, 0,0); add(0,0,0, 1,0,1,0, 0,0);

      repeat (6) begin
         @(negedge c);
         left = ~left;
         right = ~left;
         clr = left;
      end
      chk("rst_left_cnt", int'(lc0), 0);
      chk("rst_right_cnt", int'(rc0), 0);
      chk("rst_bal", int'(b0), 0);
      chk("rst_state", int'(st0), 0);
      chk("rst_req_inc", int'(ri0), 0);
      chk("rst_req_rev", int'(rr0), 0);
      chk("rst_sat", int'(s0), 0);
      chk("rst_u1_left_cnt", int'(lc1), 0);
      chk("rst_u1_bal", int'(b1), 0);
      chk("rst_u1_sat", int'(s1), 0);
      rn = 1;
      foreach (tbl[i]) begin
         left = tbl[i].l;
         right = tbl[i].r;
         clr = tbl[i].k;
         q.push_back(tbl[i]);
         @(negedge c);
      end
      left = 0;
      right = 0;
      clr = 0;
      repeat (2) @(negedge c);
      chk("queue_drained", q.size(), 0);

      clr = 1;
      @(negedge c);
      clr = 0;
      for (int i = 0; i < 16; i++) begin
         left = 1;
         @(negedge c);
         left = 0;
         @(negedge c);
         if (i == 14) begin
            chk("sat_u1_cnt_at_15", int'(lc1), 15);
            chk("sat_u1_not_yet", int'(s1), 0);
         end
      end
      chk("sat_u1_left_cnt", int'(lc1), 15);
      chk("sat_u1_bal", int'($signed(b1)), 15);
      chk("sat_u1_flag", int'(s1), 1);
      chk("sat_u1_state", int'(st1), 3);
      chk("sat_u0_left_cnt", int'(lc0), 16);
      chk("sat_u0_no_sat", int'(s0), 0);
      repeat (3) @(negedge c);
      chk("sat_u1_sticky", int'(s1), 1);
      clr = 1;
      @(negedge c);
      clr = 0;
      chk("sat_u1_clr_flag", int'(s1), 0);
      chk("sat_u1_clr_cnt", int'(lc1), 0);
      chk("sat_u1_clr_state", int'(st1), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
